// File: rtl/spi_byte_master_pkg.sv
// rtl/spi_byte_master_pkg.sv - state encodings and reset constants for spi_byte_master
package spi_byte_master_pkg;

  // Transfer sequencer states; the encoding is also the read-back layout used by tk1.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCK_LO = 2'd1,
    ST_SCK_HI = 2'd2,
    ST_DONE   = 2'd3
  } spi_state_t;

  localparam logic       RST_SS      = 1'b1;
  localparam logic       RST_SCK     = 1'b0;
  localparam logic       RST_MOSI    = 1'b0;
  localparam logic       RST_READY   = 1'b1;
  localparam logic [7:0] RST_RX_DATA = 8'h00;

endpackage

// File: rtl/spi_clk_div.sv
// rtl/spi_clk_div.sv - SCK phase counter producing a one-cycle phase_done tick
module spi_clk_div
  import spi_byte_master_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic run,
  output logic phase_done
);

  localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

  logic [7:0] cnt;

  assign phase_done = run && (cnt == 8'd0);

  // Count down through one SCK half-period; reload on every phase change, start or abort.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= RELOAD;
    end else if (clear || !run || (cnt == 8'd0)) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - 8'd1;
    end
  end

endmodule

// File: rtl/spi_byte_master.sv
// rtl/spi_byte_master.sv - mode-0 MSB-first byte SPI master; optional SPI_BYTE_MASTER_LOOPBACK_EN
module spi_byte_master
  import spi_byte_master_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       spi_enable,
  input  logic       spi_enable_vld,
  input  logic       spi_start,
  input  logic [7:0] spi_tx_data,
  input  logic       spi_tx_data_vld,
  output logic [7:0] spi_rx_data,
  output logic       spi_ready,
  output logic       spi_ss,
  output logic       spi_sck,
  output logic       spi_mosi,
`ifdef SPI_BYTE_MASTER_LOOPBACK_EN
  input  logic       spi_loopback,
`endif
  input  logic       spi_miso
);

  spi_state_t state, state_nxt;

  logic       enable_reg, enable_nxt;
  logic [7:0] tx_reg, tx_nxt;
  logic [7:0] shift_reg, shift_nxt;
  logic [7:0] rx_shift, rx_shift_nxt;
  logic [2:0] bit_ctr, bit_ctr_nxt;
  logic       sck_nxt, mosi_nxt, ready_nxt;
  logic [7:0] rx_data_nxt;
  logic [7:0] tx_eff;
  logic       busy, div_clear, div_run, phase_done, sample_bit;

  assign busy    = (state != ST_IDLE);
  assign div_run = (state == ST_SCK_LO) || (state == ST_SCK_HI);
  assign spi_ss  = ~enable_reg;
  // A tx load arriving with the start strobe wins over the held tx_reg.
  assign tx_eff  = spi_tx_data_vld ? spi_tx_data : tx_reg;

`ifdef SPI_BYTE_MASTER_LOOPBACK_EN
  assign sample_bit = spi_loopback ? spi_mosi : spi_miso;
`else
  assign sample_bit = spi_miso;
`endif

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (div_clear),
    .run       (div_run),
    .phase_done(phase_done)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable_reg  <= 1'b0;
      tx_reg      <= 8'h00;
      shift_reg   <= 8'h00;
      rx_shift    <= 8'h00;
      bit_ctr     <= 3'd0;
      spi_sck     <= RST_SCK;
      spi_mosi    <= RST_MOSI;
      spi_ready   <= RST_READY;
      spi_rx_data <= RST_RX_DATA;
    end else begin
      enable_reg  <= enable_nxt;
      tx_reg      <= tx_nxt;
      shift_reg   <= shift_nxt;
      rx_shift    <= rx_shift_nxt;
      bit_ctr     <= bit_ctr_nxt;
      spi_sck     <= sck_nxt;
      spi_mosi    <= mosi_nxt;
      spi_ready   <= ready_nxt;
      spi_rx_data <= rx_data_nxt;
    end
  end

  // Next-state and next-output decode; a chip-select drop while busy overrides everything.
  always_comb begin
    state_nxt    = state;
    enable_nxt   = enable_reg;
    tx_nxt       = tx_reg;
    shift_nxt    = shift_reg;
    rx_shift_nxt = rx_shift;
    bit_ctr_nxt  = bit_ctr;
    sck_nxt      = spi_sck;
    mosi_nxt     = spi_mosi;
    ready_nxt    = spi_ready;
    rx_data_nxt  = spi_rx_data;
    div_clear    = 1'b0;

    if (spi_enable_vld) begin
      enable_nxt = spi_enable;
    end
    if (spi_tx_data_vld && !busy) begin
      tx_nxt = spi_tx_data;
    end

    case (state)
      ST_IDLE: begin
        if (spi_start && enable_reg) begin
          shift_nxt   = tx_eff;
          bit_ctr_nxt = 3'd0;
          mosi_nxt    = tx_eff[7];
          ready_nxt   = 1'b0;
          div_clear   = 1'b1;
          state_nxt   = ST_SCK_LO;
        end
      end
      ST_SCK_LO: begin
        if (phase_done) begin
          sck_nxt      = 1'b1;
          rx_shift_nxt = {rx_shift[6:0], sample_bit};
          state_nxt    = ST_SCK_HI;
        end
      end
      ST_SCK_HI: begin
        if (phase_done) begin
          sck_nxt     = 1'b0;
          shift_nxt   = {shift_reg[6:0], 1'b0};
          mosi_nxt    = shift_reg[6];
          bit_ctr_nxt = bit_ctr + 3'd1;
          state_nxt   = (bit_ctr == 3'd7) ? ST_DONE : ST_SCK_LO;
        end
      end
      ST_DONE: begin
        rx_data_nxt = rx_shift;
        ready_nxt   = 1'b1;
        mosi_nxt    = 1'b0;
        state_nxt   = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (busy && spi_enable_vld && !spi_enable) begin
      state_nxt   = ST_IDLE;
      sck_nxt     = 1'b0;
      mosi_nxt    = 1'b0;
      ready_nxt   = 1'b1;
      rx_data_nxt = spi_rx_data;
      div_clear   = 1'b1;
    end
  end

endmodule

// File: tb/tb_spi_byte_master.sv
// tb/tb_spi_byte_master.sv - self-checking bench for spi_byte_master
module tb_spi_byte_master;

  localparam int unsigned CLK_DIV = 2;
  localparam int          CLK_PERIOD = 10;
  localparam int          EXP_LAT = 16 * CLK_DIV + 1;
  localparam time         EXP_SCK_PERIOD = 2 * CLK_DIV * CLK_PERIOD;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       spi_enable, spi_enable_vld, spi_start, spi_tx_data_vld;
  logic [7:0] spi_tx_data;
  logic [7:0] spi_rx_data;
  logic       spi_ready, spi_ss, spi_sck, spi_mosi, spi_miso;
`ifdef SPI_BYTE_MASTER_LOOPBACK_EN
  logic       spi_loopback;
`endif

  int total = 0;
  int bad = 0;

  // Slave model and observation state.
  logic [7:0] slave_byte = 8'h00;
  logic [3:0] bit_idx = 4'd0;
  logic [7:0] mosi_cap = 8'h00;
  int         rises = 0;
  int         period_err = 0;
  time        last_rise = 0;
  logic [7:0] last_rx = 8'h00;

  always #(CLK_PERIOD / 2) clk = ~clk;

  spi_byte_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .spi_enable     (spi_enable),
    .spi_enable_vld (spi_enable_vld),
    .spi_start      (spi_start),
    .spi_tx_data    (spi_tx_data),
    .spi_tx_data_vld(spi_tx_data_vld),
    .spi_rx_data    (spi_rx_data),
    .spi_ready      (spi_ready),
    .spi_ss         (spi_ss),
    .spi_sck        (spi_sck),
    .spi_mosi       (spi_mosi),
`ifdef SPI_BYTE_MASTER_LOOPBACK_EN
    .spi_loopback   (spi_loopback),
`endif
    .spi_miso       (spi_miso)
  );

  // Mode-0 slave: present the next bit after every falling SCK edge.
  assign spi_miso = (bit_idx < 4'd8) ? slave_byte[3'd7 - bit_idx[2:0]] : 1'b0;

  always @(negedge spi_sck) bit_idx = bit_idx + 4'd1;

  always @(posedge spi_sck) begin
    if (rises > 0 && ($time - last_rise) != EXP_SCK_PERIOD) period_err = period_err + 1;
    last_rise = $time;
    mosi_cap = {mosi_cap[6:0], spi_mosi};
    rises = rises + 1;
  end

  task automatic set_enable(input logic v);
    spi_enable = v;
    spi_enable_vld = 1'b1;
    @(negedge clk);
    spi_enable_vld = 1'b0;
  endtask

  // Issue a start strobe (optionally with a tx load) from a negedge.
  task automatic launch(input logic [7:0] tx, input logic [7:0] slv, input bit load_tx);
    slave_byte = slv;
    bit_idx = 4'd0;
    rises = 0;
    period_err = 0;
    mosi_cap = 8'h00;
    if (load_tx) begin
      spi_tx_data = tx;
      spi_tx_data_vld = 1'b1;
    end
    spi_start = 1'b1;
    @(negedge clk);
    spi_start = 1'b0;
    spi_tx_data_vld = 1'b0;
  endtask

  // Wait for spi_ready, optionally firing stray start/tx strobes at cycle inject_at.
  task automatic wait_ready(input int inject_at, output int lat);
    int c = 1;
    while (spi_ready !== 1'b1 && c < 1000) begin
      if (c == inject_at) begin
        spi_start = 1'b1;
        spi_tx_data_vld = 1'b1;
        spi_tx_data = 8'hFF;
      end
      @(negedge clk);
      spi_start = 1'b0;
      spi_tx_data_vld = 1'b0;
      c++;
    end
    lat = c - 1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if ({spi_ss, spi_sck, spi_mosi, spi_ready} !== 4'b1001) begin bad++; $display("FAIL reset_ctrl got=%b exp=1001", {spi_ss, spi_sck, spi_mosi, spi_ready}); end
    total++; if (spi_rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx got=%h exp=00", spi_rx_data); end
    reset_n = 1'b1;
    @(negedge clk);
    total++; if ({spi_ss, spi_sck, spi_ready} !== 3'b101) begin bad++; $display("FAIL post_reset got=%b exp=101", {spi_ss, spi_sck, spi_ready}); end
  endtask

  task automatic test_basic();
    int lat;
    set_enable(1'b1);
    total++; if (spi_ss !== 1'b0) begin bad++; $display("FAIL ss_enable got=%b exp=0", spi_ss); end
    launch(8'hA5, 8'h3C, 1'b1);
    total++; if (spi_ready !== 1'b0) begin bad++; $display("FAIL busy_ready got=%b exp=0", spi_ready); end
    wait_ready(0, lat);
    last_rx = 8'h3C;
    total++; if (lat != EXP_LAT) begin bad++; $display("FAIL basic_latency got=%0d exp=%0d", lat, EXP_LAT); end
    total++; if (spi_rx_data !== last_rx) begin bad++; $display("FAIL basic_rx got=%h exp=%h", spi_rx_data, last_rx); end
    total++; if (mosi_cap !== 8'hA5) begin bad++; $display("FAIL basic_mosi got=%h exp=a5", mosi_cap); end
    total++; if (rises != 8) begin bad++; $display("FAIL basic_pulses got=%0d exp=8", rises); end
    total++; if (period_err != 0) begin bad++; $display("FAIL basic_sck_period bad_periods=%0d exp=0", period_err); end
    total++; if ({spi_sck, spi_mosi} !== 2'b00) begin bad++; $display("FAIL basic_idle_lines got=%b exp=00", {spi_sck, spi_mosi}); end
  endtask

  task automatic test_busy_ignore();
    int lat;
    launch(8'hA5, 8'h96, 1'b1);
    wait_ready(5, lat);
    last_rx = 8'h96;
    total++; if (rises != 8) begin bad++; $display("FAIL busy_pulses got=%0d exp=8", rises); end
    total++; if (lat != EXP_LAT) begin bad++; $display("FAIL busy_latency got=%0d exp=%0d", lat, EXP_LAT); end
    total++; if (spi_rx_data !== last_rx) begin bad++; $display("FAIL busy_rx got=%h exp=%h", spi_rx_data, last_rx); end
    repeat (3) @(negedge clk);
    total++; if (spi_ready !== 1'b1 || rises != 8) begin bad++; $display("FAIL busy_restart ready=%b pulses=%0d exp ready=1 pulses=8", spi_ready, rises); end
    launch(8'h00, 8'h5A, 1'b0);
    wait_ready(0, lat);
    last_rx = 8'h5A;
    total++; if (mosi_cap !== 8'hA5) begin bad++; $display("FAIL busy_tx_kept got=%h exp=a5", mosi_cap); end
    total++; if (spi_rx_data !== last_rx) begin bad++; $display("FAIL busy_rx2 got=%h exp=%h", spi_rx_data, last_rx); end
  endtask

  task automatic test_abort();
    int c = 0;
    launch(8'hF0, 8'hE7, 1'b1);
    while (rises < 3 && c < 200) begin @(negedge clk); c++; end
    total++; if (rises < 3) begin bad++; $display("FAIL abort_wait pulses=%0d exp=3", rises); end
    set_enable(1'b0);
    total++; if ({spi_ss, spi_sck, spi_mosi, spi_ready} !== 4'b1001) begin bad++; $display("FAIL abort_lines got=%b exp=1001", {spi_ss, spi_sck, spi_mosi, spi_ready}); end
    total++; if (spi_rx_data !== last_rx) begin bad++; $display("FAIL abort_rx got=%h exp=%h", spi_rx_data, last_rx); end
    repeat (40) @(negedge clk);
    total++; if (rises != 3) begin bad++; $display("FAIL abort_quiet pulses=%0d exp=3", rises); end
  endtask

  task automatic test_disabled_start();
    int drops = 0;
    launch(8'h81, 8'h18, 1'b1);
    for (int i = 0; i < 100; i++) begin
      if (spi_ready !== 1'b1) drops++;
      @(negedge clk);
    end
    total++; if (drops != 0 || rises != 0) begin bad++; $display("FAIL disabled_start ready_drops=%0d pulses=%0d exp 0 0", drops, rises); end
    total++; if (spi_rx_data !== last_rx) begin bad++; $display("FAIL disabled_rx got=%h exp=%h", spi_rx_data, last_rx); end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [7:0] tx, slv;
    set_enable(1'b1);
    for (int n = 0; n < 8; n++) begin
      tx = 8'($urandom);
      slv = 8'($urandom);
      launch(tx, slv, 1'b1);
      wait_ready(0, lat);
      last_rx = slv;
      total++; if (spi_rx_data !== slv || mosi_cap !== tx) begin bad++; $display("FAIL b2b_data n=%0d rx=%h exp=%h mosi=%h exp=%h", n, spi_rx_data, slv, mosi_cap, tx); end
      total++; if (lat != EXP_LAT || rises != 8 || period_err != 0) begin bad++; $display("FAIL b2b_timing n=%0d lat=%0d exp=%0d pulses=%0d bad_periods=%0d", n, lat, EXP_LAT, rises, period_err); end
    end
  endtask

`ifdef SPI_BYTE_MASTER_LOOPBACK_EN
  task automatic test_loopback();
    int lat;
    spi_loopback = 1'b1;
    launch(8'hC3, 8'h00, 1'b1);
    wait_ready(0, lat);
    spi_loopback = 1'b0;
    total++; if (spi_rx_data !== 8'hC3) begin bad++; $display("FAIL loopback_rx got=%h exp=c3", spi_rx_data); end
    last_rx = 8'hC3;
  endtask
`endif

  task automatic test_async_reset();
    launch(8'hFF, 8'h00, 1'b1);
    repeat (10) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    total++; if ({spi_ss, spi_sck, spi_mosi, spi_ready} !== 4'b1001) begin bad++; $display("FAIL async_reset_lines got=%b exp=1001", {spi_ss, spi_sck, spi_mosi, spi_ready}); end
    total++; if (spi_rx_data !== 8'h00) begin bad++; $display("FAIL async_reset_rx got=%h exp=00", spi_rx_data); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    spi_enable = 1'b0;
    spi_enable_vld = 1'b0;
    spi_start = 1'b0;
    spi_tx_data = 8'h00;
    spi_tx_data_vld = 1'b0;
`ifdef SPI_BYTE_MASTER_LOOPBACK_EN
    spi_loopback = 1'b0;
`endif
    test_reset();
    test_basic();
    test_busy_ignore();
    test_abort();
    test_disabled_start();
    test_back_to_back();
`ifdef SPI_BYTE_MASTER_LOOPBACK_EN
    test_loopback();
`endif
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
